// File: rtl/msi_axi_writer_pkg.sv
// msi_axi_writer_pkg: SoC constants and types shared by the MSI writer and its FIFO
package msi_axi_writer_pkg;
  localparam logic [63:0] ImsicBase = 64'h2400_0000;
  localparam logic [63:0] ImsicLength = 64'h0010_0000;
  localparam int unsigned NrIntpFiles = 2;
  localparam int unsigned IdWidth = 4;
  localparam logic [63:0] FileStride = 64'h1000;
  localparam logic [63:0] SeteipnumLeOffset = 64'h0;
  typedef enum logic [$clog2(NrIntpFiles)-1:0] {IntpFileM, IntpFileS} aia_intp_files_t;
  typedef enum logic [1:0] {Idle, Send, Resp} state_t;
endpackage

// File: rtl/msi_req_fifo.sv
// msi_req_fifo: pointer-based request FIFO; full/empty come straight from registered pointers
module msi_req_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned Aw = $clog2(Depth);
  logic [Width-1:0] mem [Depth];
  logic [Aw:0] wptr, rptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= push ? wptr + (Aw+1)'(1) : wptr;
      rptr <= pop ? rptr + (Aw+1)'(1) : rptr;
    end
  end
  always_ff @(posedge clk) if (push) mem[wptr[Aw-1:0]] <= wdata;
  assign rdata = mem[rptr[Aw-1:0]];
  assign empty = wptr == rptr;
  assign full = (wptr[Aw] != rptr[Aw]) && (wptr[Aw-1:0] == rptr[Aw-1:0]);
endmodule

// File: rtl/msi_axi_writer.sv
// msi_axi_writer: queues interrupt requests and issues each as a single-beat AXI write to seteipnum_le
module msi_axi_writer #(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned NrIntpFiles = msi_axi_writer_pkg::NrIntpFiles,
  parameter int unsigned EiidWidth = 11,
  parameter logic [63:0] ImsicBase = msi_axi_writer_pkg::ImsicBase,
  parameter logic [63:0] FileStride = msi_axi_writer_pkg::FileStride,
  parameter int unsigned IdWidth = msi_axi_writer_pkg::IdWidth,
  parameter logic [IdWidth-1:0] AxiId = '0,
  localparam int unsigned FileW = NrIntpFiles > 1 ? $clog2(NrIntpFiles) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [FileW-1:0]     req_file_i,
  input  logic [EiidWidth-1:0] req_eiid_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [63:0]          aw_addr_o,
  output logic [IdWidth-1:0]   aw_id_o,
  output logic [7:0]           aw_len_o,
  output logic [2:0]           aw_size_o,
  output logic [1:0]           aw_burst_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [63:0]          w_data_o,
  output logic [7:0]           w_strb_o,
  output logic                 w_last_o,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [1:0]           b_resp_i,
  output logic                 drop_o,
  output logic                 err_o,
  output logic [7:0]           err_cnt_o,
  output logic                 busy_o
);
  import msi_axi_writer_pkg::*;
  localparam int unsigned EntryW = FileW + EiidWidth;
  state_t state, state_d;
  logic full, empty, accept, legal, push, pop, resp_err;
  logic aw_q, w_q, b_q, aw_d, w_d, b_d, drop_q, err_q, busy_q;
  logic [EntryW-1:0] head;
  logic [63:0] addr_q, data_q;
  logic [7:0] err_cnt_q;
  assign req_ready_o = !rst_i && !full;
  assign accept = req_valid_i && req_ready_o;
  assign legal = 32'(req_file_i) < NrIntpFiles && req_eiid_i != '0;
  assign push = accept && legal;
  assign resp_err = state == Resp && b_valid_i && b_resp_i != 2'b00;
  msi_req_fifo #(.Depth(FifoDepth), .Width(EntryW)) u_fifo (
    .clk(clk_i), .rst(rst_i), .push(push), .pop(pop),
    .wdata({req_file_i, req_eiid_i}), .rdata(head), .full(full), .empty(empty)
  );
  always_comb begin
    state_d = state;
    aw_d = aw_q;
    w_d = w_q;
    b_d = b_q;
    pop = 1'b0;
    case (state)
      Idle: if (!empty) begin
        pop = 1'b1;
        aw_d = 1'b1;
        w_d = 1'b1;
        state_d = Send;
      end
      Send: begin
        aw_d = aw_q && !aw_ready_i;
        w_d = w_q && !w_ready_i;
        if (!aw_d && !w_d) begin
          b_d = 1'b1;
          state_d = Resp;
        end
      end
      Resp: if (b_valid_i) begin
        b_d = 1'b0;
        state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= Idle;
      aw_q <= 1'b0;
      w_q <= 1'b0;
      b_q <= 1'b0;
      drop_q <= 1'b0;
      err_q <= 1'b0;
      err_cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state <= state_d;
      aw_q <= aw_d;
      w_q <= w_d;
      b_q <= b_d;
      drop_q <= accept && !legal;
      err_q <= resp_err;
      err_cnt_q <= resp_err && err_cnt_q != 8'hFF ? err_cnt_q + 8'd1 : err_cnt_q;
      busy_q <= !empty || state != Idle;
    end
  end
  // payload is captured once at pop and held until the next pop
  always_ff @(posedge clk_i) begin
    if (pop) begin
      addr_q <= ImsicBase + 64'(head[EntryW-1 -: FileW]) * FileStride + SeteipnumLeOffset;
      data_q <= 64'(head[EiidWidth-1:0]);
    end
  end
  assign aw_valid_o = aw_q;
  assign aw_addr_o = addr_q;
  assign aw_id_o = AxiId;
  assign aw_len_o = 8'd0;
  assign aw_size_o = 3'b010;
  assign aw_burst_o = 2'b01;
  assign w_valid_o = w_q;
  assign w_data_o = data_q;
  assign w_strb_o = 8'h0F;
  assign w_last_o = 1'b1;
  assign b_ready_o = b_q;
  assign drop_o = drop_q;
  assign err_o = err_q;
  assign err_cnt_o = err_cnt_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_msi_axi_writer.sv
// tb_msi_axi_writer: randomized slave and request traffic checked against a transaction-level model
module tb_msi_axi_writer;
  localparam int NF = 3;
  logic clk = 1'b0;
  logic rst_i, req_valid_i, req_ready_o;
  logic [1:0] req_file_i;
  logic [10:0] req_eiid_i;
  logic aw_valid_o, aw_ready_i, w_valid_o, w_ready_i, w_last_o, b_valid_i, b_ready_o;
  logic [63:0] aw_addr_o, w_data_o;
  logic [3:0] aw_id_o;
  logic [7:0] aw_len_o, w_strb_o, err_cnt_o;
  logic [2:0] aw_size_o;
  logic [1:0] aw_burst_o, b_resp_i;
  logic drop_o, err_o, busy_o;
  always #5 clk = ~clk;

  msi_axi_writer #(.NrIntpFiles(NF)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_file_i(req_file_i), .req_eiid_i(req_eiid_i), .aw_valid_o(aw_valid_o),
    .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_id_o(aw_id_o), .aw_len_o(aw_len_o),
    .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o), .b_valid_i(b_valid_i),
    .b_ready_o(b_ready_o), .b_resp_i(b_resp_i), .drop_o(drop_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o), .busy_o(busy_o)
  );

  typedef struct packed {logic [63:0] addr; logic [63:0] data;} wr_t;
  wr_t exp_q[$];
  int checks = 0, errors = 0;
  int n_aw = 0, n_w = 0, n_b = 0, n_drop = 0, n_err = 0, n_push = 0;
  int exp_cnt = 0, s1 = 0, s2 = 0;
  bit aw_seen, w_seen, aw_wait, w_wait, exp_drop, exp_err;
  int aw_pct = 100, w_pct = 100, err_pct = 0, bdly_max = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // reference model: every accepted legal request becomes exactly one write, in order
  always @(negedge clk) begin
    bit bhs, acc, lg;
    if (rst_i) begin
      chk("ready_in_reset", req_ready_o, 0);
      exp_q.delete();
      {aw_seen, w_seen, aw_wait, w_wait, exp_drop, exp_err} = '0;
      exp_cnt = 0; s1 = 0; s2 = 0;
    end else begin
      chk("drop", drop_o, exp_drop);
      chk("err", err_o, exp_err);
      chk("err_cnt", err_cnt_o, exp_cnt);
      chk("busy", busy_o, s2 != 0);
      chk("aw_idle", aw_valid_o && exp_q.size() == 0, 0);
      chk("w_idle", w_valid_o && exp_q.size() == 0, 0);
      if (aw_wait) chk("aw_hold", aw_valid_o, 1);
      if (w_wait) chk("w_hold", w_valid_o, 1);
      if (aw_valid_o && exp_q.size() != 0) begin
        chk("aw_addr", aw_addr_o, exp_q[0].addr);
        chk("aw_attr", {aw_id_o, aw_len_o, aw_size_o, aw_burst_o}, {4'd0, 8'd0, 3'd2, 2'd1});
        chk("aw_dup", aw_seen, 0);
      end
      if (w_valid_o && exp_q.size() != 0) begin
        chk("w_data", w_data_o, exp_q[0].data);
        chk("w_attr", {w_strb_o, w_last_o}, {8'h0F, 1'b1});
        chk("w_dup", w_seen, 0);
      end
      if (b_ready_o) chk("b_early", {aw_seen, w_seen}, 2'b11);
      bhs = b_valid_i && b_ready_o;
      if (bhs) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        aw_seen = 0; w_seen = 0; n_b++;
      end
      if (aw_valid_o && aw_ready_i) begin aw_seen = 1; n_aw++; end
      if (w_valid_o && w_ready_i) begin w_seen = 1; n_w++; end
      aw_wait = aw_valid_o && !aw_ready_i;
      w_wait = w_valid_o && !w_ready_i;
      exp_err = bhs && b_resp_i != 2'b00;
      if (exp_err && exp_cnt < 255) exp_cnt++;
      acc = req_valid_i && req_ready_o;
      lg = int'(req_file_i) < NF && req_eiid_i != 0;
      exp_drop = acc && !lg;
      if (acc && lg) begin
        exp_q.push_back('{64'h2400_0000 + 64'(req_file_i) * 64'h1000, 64'(req_eiid_i)});
        n_push++;
      end
      if (drop_o) n_drop++;
      if (err_o) n_err++;
      s2 = s1; s1 = exp_q.size();
    end
  end

  // AXI slave: random ready, B returned after both AW and W handshakes
  initial begin
    bit ad, wd, bv;
    logic [1:0] rsp;
    ad = 0; wd = 0; bv = 0; rsp = 0;
    aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        ad = 0; wd = 0; bv = 0;
      end else begin
        if (aw_valid_o && aw_ready_i) ad = 1;
        if (w_valid_o && w_ready_i) wd = 1;
        if (b_valid_i && b_ready_o) begin
          ad = 0; wd = 0; bv = 0;
        end else if (ad && wd && !bv && $urandom_range(0, bdly_max) == 0) begin
          bv = 1;
          rsp = $urandom_range(1, 100) <= err_pct ? 2'b10 : 2'b00;
        end
      end
      @(posedge clk); #2;
      aw_ready_i = $urandom_range(1, 100) <= aw_pct;
      w_ready_i = $urandom_range(1, 100) <= w_pct;
      b_valid_i = bv;
      b_resp_i = bv ? rsp : 2'b00;
    end
  end

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic send(input int f, input int e);
    bit got = 0;
    req_valid_i = 1; req_file_i = 2'(f); req_eiid_i = 11'(e);
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      got = req_ready_o;
    end
    if (!got) chk("send_timeout", got, 1);
    align();
    req_valid_i = 0;
  endtask

  task automatic wait_aw(output int lat);
    bit got = 0;
    lat = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      lat++;
      got = aw_valid_o;
    end
    if (!got) chk("aw_timeout", got, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      done = exp_q.size() == 0 && !busy_o && !aw_valid_o && !w_valid_o;
    end
    if (!done) chk("idle_timeout", done, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int lat, acc, blk, held, b0, aw0, w0, d0, e0, p0;
    rst_i = 1; req_valid_i = 0; req_file_i = 0; req_eiid_i = 0;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    @(negedge clk);
    chk("rst_valids", {aw_valid_o, w_valid_o, b_ready_o, drop_o, err_o}, 5'b0);
    chk("rst_cnt", err_cnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", req_ready_o, 1);
    align();
    // single request, always-ready slave
    b0 = n_b;
    send(1, 5);
    wait_aw(lat);
    chk("t1_latency", lat, 2);
    chk("t1_addr", aw_addr_o, 64'h2400_1000);
    chk("t1_data", w_data_o, 64'h5);
    chk("t1_strb_last", {w_strb_o, w_last_o}, {8'h0F, 1'b1});
    wait_idle();
    chk("t1_busy_done", busy_o, 0);
    chk("t1_one_b", n_b - b0, 1);
    align();
    // W accepted well before AW
    aw_pct = 0; w_pct = 0; b0 = n_b; aw0 = n_aw; w0 = n_w;
    send(1, 7);
    wait_aw(lat);
    align();
    w_pct = 100;
    @(posedge clk);
    @(negedge clk);
    chk("t2_w_first", {aw_valid_o, w_valid_o}, 2'b10);
    @(posedge clk);
    @(posedge clk); #1;
    aw_pct = 100;
    wait_idle();
    chk("t2_counts", {8'(n_aw - aw0), 8'(n_w - w0), 8'(n_b - b0)}, {8'd1, 8'd1, 8'd1});
    align();
    // fill the FIFO behind a stalled write
    aw_pct = 0; req_valid_i = 1; acc = 0; blk = -1; held = -1;
    for (int k = 0; k < 60 && acc < 6; k++) begin
      req_file_i = 2'(acc % 3); req_eiid_i = 11'(100 + acc);
      @(negedge clk);
      if (req_ready_o) acc++;
      else if (blk < 0) blk = acc;
      if (k == 12) begin held = acc; aw_pct = 100; end
      align();
    end
    req_valid_i = 0;
    chk("t3_block_at", blk, 5);
    chk("t3_held_full", held, 5);
    chk("t3_all_in", acc, 6);
    wait_idle();
    align();
    // illegal requests are dropped without bus activity
    d0 = n_drop; aw0 = n_aw;
    send(3, 9);
    send(0, 0);
    repeat (5) @(negedge clk);
    chk("t4_drops", n_drop - d0, 2);
    chk("t4_no_aw", n_aw - aw0, 0);
    align();
    // error responses and saturation
    err_pct = 100; e0 = n_err;
    for (int i = 0; i < 3; i++) send(1, i + 1);
    wait_idle();
    chk("t5_err_pulses", n_err - e0, 3);
    chk("t5_err_cnt", err_cnt_o, 3);
    align();
    for (int i = 0; i < 252; i++) send(0, 9);
    wait_idle();
    chk("t5_err_255", err_cnt_o, 255);
    align();
    send(2, 4);
    wait_idle();
    chk("t5_err_sat", err_cnt_o, 255);
    chk("t5_err_total", n_err - e0, 256);
    align();
    // reset while a write is in flight
    err_pct = 0; aw_pct = 0;
    send(2, 33);
    wait_aw(lat);
    align();
    rst_i = 1;
    align();
    rst_i = 0;
    @(negedge clk);
    chk("t6_valids", {aw_valid_o, w_valid_o, b_ready_o}, 3'b0);
    chk("t6_cnt", err_cnt_o, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_ready", req_ready_o, 1);
    aw_pct = 100;
    align();
    // random traffic
    aw_pct = 70; w_pct = 70; err_pct = 25; bdly_max = 3; b0 = n_b; p0 = n_push;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) repeat (1 + $urandom_range(0, 2)) align();
      else send($urandom_range(0, 3), $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 2047));
    end
    wait_idle();
    chk("rand_all_written", n_b - b0, n_push - p0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
